// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic constants for the q = 3329 ring.
// Also holds the modular halving helper used before output registers.
package ntt_pkg;

  localparam int MODULUS       = 3329;
  localparam int HALF_INV      = 1665;
  localparam int BARRETT_K     = 5039;
  localparam int BARRETT_SHIFT = 24;

  // x * 2^-1 mod q for x in [0, q-1]
  function automatic logic [15:0] half_mod(
    input logic [15:0] x,
    input logic [15:0] q
  );
    logic [16:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return t[16:1];
  endfunction

endpackage

// File: rtl/inv_bf_barrett_mul.sv
// Pipelined Barrett modular multiplier, valid travels with data.
// Final conditional subtract is combinational into the caller's register.
module inv_bf_barrett_mul #(
  parameter int DW = 12,
  parameter int Q  = 3329
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_valid,
  input  logic [DW:0]   i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_valid,
  output logic [DW-1:0] o_res
);
  import ntt_pkg::*;

  localparam int PW = 2 * DW;
  localparam int KW = DW + 1;
  localparam int MW = PW + KW;
  localparam int KV = (Q == MODULUS) ? BARRETT_K
                    : (1 << BARRETT_SHIFT) / Q;
  localparam logic [MW-1:0] K_L  = MW'(KV);
  localparam logic [DW:0]   Q_R  = (DW+1)'(Q);

  logic [3:0]    r_v;
  logic [PW-1:0] r_prod;
  logic [MW-1:0] r_m;
  logic [PW-1:0] r_x2;
  logic [PW-1:0] r_x3;
  logic [KW-1:0] r_qe;
  logic [DW:0]   r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_prod <= '0;
      r_m    <= '0;
      r_x2   <= '0;
      r_x3   <= '0;
      r_qe   <= '0;
      r_rem  <= '0;
    end else if (i_en) begin
      r_v    <= {r_v[2:0], i_valid};
      r_prod <= PW'(i_a) * PW'(i_b);
      r_m    <= MW'(r_prod) * K_L;
      r_x2   <= r_prod;
      r_qe   <= KW'(r_m >> BARRETT_SHIFT);
      r_x3   <= r_x2;
      // quotient estimate is low by at most one, so rem < 2q
      r_rem  <= (DW+1)'(r_x3 - PW'(r_qe) * PW'(Q));
    end
  end

  assign o_valid = r_v[3];
  assign o_res   = (r_rem >= Q_R) ? DW'(r_rem - Q_R)
                                  : DW'(r_rem);

endmodule

// File: rtl/inv_butterfly_unit.sv
// Gentleman-Sande inverse NTT butterfly, six-stage pipeline.
// Optional per-sample scaling by 2^-1 mod q on both outputs.
module inv_butterfly_unit #(
  parameter int DATA_WIDTH = 12,
  parameter int MODULUS    = 3329
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] twiddle,
  input  logic                  scale_en,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  valid_out
);
  import ntt_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int IW = DATA_WIDTH + 1;
  localparam int DL = 4;
  localparam logic [IW-1:0] QI = IW'(MODULUS);

  logic [IW-1:0] w_sum_raw;
  logic [IW-1:0] w_sum;
  logic [IW-1:0] w_dif;
  logic          w_mv;
  logic [DW-1:0] w_mres;
  logic [DW-1:0] w_a_fin;
  logic [DW-1:0] w_b_fin;

  logic [IW-1:0] r_s1_sum;
  logic [IW-1:0] r_s1_dif;
  logic [DW-1:0] r_s1_tw;
  logic          r_s1_scl;
  logic          r_s1_v;
  logic [IW-1:0] r_sum_d [DL];
  logic          r_scl_d [DL];

  always_comb begin
    w_sum_raw = {1'b0, a_in} + {1'b0, b_in};
    w_sum     = (w_sum_raw >= QI) ? w_sum_raw - QI : w_sum_raw;
    w_dif     = (a_in >= b_in) ? {1'b0, a_in} - {1'b0, b_in}
                               : {1'b0, a_in} + QI - {1'b0, b_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_sum <= '0;
      r_s1_dif <= '0;
      r_s1_tw  <= '0;
      r_s1_scl <= 1'b0;
      r_s1_v   <= 1'b0;
    end else if (enable) begin
      r_s1_sum <= w_sum;
      r_s1_dif <= w_dif;
      r_s1_tw  <= twiddle;
      r_s1_scl <= scale_en;
      r_s1_v   <= valid_in;
    end
  end

  inv_bf_barrett_mul #(
    .DW (DW),
    .Q  (MODULUS)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (enable),
    .i_valid (r_s1_v),
    .i_a     (r_s1_dif),
    .i_b     (r_s1_tw),
    .o_valid (w_mv),
    .o_res   (w_mres)
  );

  // sum and scale flag ride alongside the multiplier registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DL; i++) begin
        r_sum_d[i] <= '0;
        r_scl_d[i] <= 1'b0;
      end
    end else if (enable) begin
      r_sum_d[0] <= r_s1_sum;
      r_scl_d[0] <= r_s1_scl;
      for (int i = 1; i < DL; i++) begin
        r_sum_d[i] <= r_sum_d[i-1];
        r_scl_d[i] <= r_scl_d[i-1];
      end
    end
  end

  always_comb begin
    w_a_fin = DW'(r_sum_d[DL-1]);
    w_b_fin = w_mres;
    if (r_scl_d[DL-1]) begin
      w_a_fin = DW'(half_mod(16'(r_sum_d[DL-1]), 16'(MODULUS)));
      w_b_fin = DW'(half_mod(16'(w_mres), 16'(MODULUS)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
    end else if (enable) begin
      valid_out <= w_mv;
      if (w_mv) begin
        a_out <= w_a_fin;
        b_out <= w_b_fin;
      end
    end
  end

endmodule

// File: tb/tb_inv_butterfly_unit.sv
// Self-checking bench for inv_butterfly_unit against a queue-based model.
module tb_inv_butterfly_unit;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] a_in = '0;
  logic [11:0] b_in = '0;
  logic [11:0] twiddle = '0;
  logic        scale_en = 1'b0;
  logic [11:0] a_out;
  logic [11:0] b_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int due;
    int ea;
    int eb;
  } ent_t;

  ent_t mq[$];
  int   ecnt = 0;
  bit   exp_v = 0;
  int   exp_a = 0;
  int   exp_b = 0;

  always #5 clk = ~clk;

  inv_butterfly_unit #(
    .DATA_WIDTH (12),
    .MODULUS    (Q)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .valid_in  (valid_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .twiddle   (twiddle),
    .scale_en  (scale_en),
    .a_out     (a_out),
    .b_out     (b_out),
    .valid_out (valid_out)
  );

  function automatic void golden(input int a, input int b, input int w,
                                 input bit s, output int ra, output int rb);
    ra = (a + b) % Q;
    rb = (((a - b + Q) % Q) * w) % Q;
    if (s) begin
      ra = (ra * 1665) % Q;
      rb = (rb * 1665) % Q;
    end
  endfunction

  // one clock: drive, wait past the edge, advance the model
  task automatic cyc(input bit en, input bit v, input int a, input int b,
                     input int w, input bit s);
    int ga, gb;
    enable   = en;
    valid_in = v;
    a_in     = 12'(a);
    b_in     = 12'(b);
    twiddle  = 12'(w);
    scale_en = s;
    @(posedge clk);
    #1;
    if (en) begin
      ecnt++;
      if (v) begin
        golden(a, b, w, s, ga, gb);
        mq.push_back('{ecnt + 5, ga, gb});
      end
      exp_v = 0;
      if (mq.size() > 0 && mq[0].due == ecnt) begin
        exp_v = 1;
        exp_a = mq[0].ea;
        exp_b = mq[0].eb;
        void'(mq.pop_front());
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_v = 0;
    exp_a = 0;
    exp_b = 0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b exp 0", valid_out);
    end
    checks++;
    if (a_out !== 12'd0 || b_out !== 12'd0) begin
      errors++;
      $display("FAIL reset_data got %0d/%0d exp 0/0", a_out, b_out);
    end
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_directed();
    int va[6] = '{5, 3, 3328, 100, 1, 0};
    int vb[6] = '{3, 5, 3328, 50, 0, 0};
    int vw[6] = '{1, 1, 17, 3328, 1, 0};
    bit vs[6] = '{0, 0, 0, 0, 1, 0};
    int ea[5] = '{8, 8, 3327, 150, 1665};
    int eb[5] = '{2, 3327, 0, 3279, 1665};
    int k = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 5)
        cyc(1, 1, va[i], vb[i], vw[i], vs[i]);
      else
        cyc(1, 0, 7, 9, 11, 0);
      checks++;
      if (valid_out !== exp_v) begin
        errors++;
        $display("FAIL dir_valid cyc %0d got %0b exp %0b", i, valid_out, exp_v);
      end
      if (valid_out === 1'b1 && k < 5) begin
        checks++;
        if (a_out !== 12'(ea[k]) || b_out !== 12'(eb[k])) begin
          errors++;
          $display("FAIL dir_data %0d got %0d/%0d exp %0d/%0d",
                   k, a_out, b_out, ea[k], eb[k]);
        end
        checks++;
        if (i != k + 5) begin
          errors++;
          $display("FAIL dir_latency %0d got cyc %0d exp %0d", k, i, k + 5);
        end
        k++;
      end
    end
    checks++;
    if (k != 5) begin
      errors++;
      $display("FAIL dir_count got %0d exp 5", k);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 20; i++) begin
      bit en;
      en = !(i >= 4 && i < 7);
      if (i < 8)
        cyc(en, 1, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
            $urandom_range(0, Q - 1), 1'($urandom));
      else
        cyc(en, 0, 0, 0, 0, 0);
      checks++;
      if (valid_out !== exp_v || a_out !== 12'(exp_a) ||
          b_out !== 12'(exp_b)) begin
        errors++;
        $display("FAIL stall cyc %0d got %0b/%0d/%0d exp %0b/%0d/%0d",
                 i, valid_out, a_out, b_out, exp_v, exp_a, exp_b);
      end
    end
    checks++;
    if (mq.size() != 0) begin
      errors++;
      $display("FAIL stall_drain got %0d pending exp 0", mq.size());
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
          $urandom_range(0, Q - 1), 0);
    end
    checks++;
    if (valid_out !== 1'b1 || a_out !== 12'(exp_a) || b_out !== 12'(exp_b)) begin
      errors++;
      $display("FAIL pre_reset got %0b/%0d/%0d exp 1/%0d/%0d",
               valid_out, a_out, b_out, exp_a, exp_b);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || a_out !== 12'd0 || b_out !== 12'd0) begin
      errors++;
      $display("FAIL async_reset got %0b/%0d/%0d exp 0/0/0",
               valid_out, a_out, b_out);
    end
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 2)
        cyc(1, 1, 20, 30, 2, 0);
      else
        cyc(1, 0, 0, 0, 0, 0);
      checks++;
      if (valid_out !== exp_v || a_out !== 12'(exp_a) ||
          b_out !== 12'(exp_b)) begin
        errors++;
        $display("FAIL post_reset cyc %0d got %0b/%0d/%0d exp %0b/%0d/%0d",
                 i, valid_out, a_out, b_out, exp_v, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int guard = 0;
    while ((sent < 1000 || mq.size() != 0) && guard < 4000) begin
      bit en, v;
      guard++;
      en = ($urandom % 10) != 0;
      v  = (sent < 1000) && (($urandom % 5) != 0);
      if (en && v) sent++;
      cyc(en, v, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
          $urandom_range(0, Q - 1), 1'($urandom));
      checks++;
      if (valid_out !== exp_v || a_out !== 12'(exp_a) ||
          b_out !== 12'(exp_b)) begin
        errors++;
        $display("FAIL random cyc %0d got %0b/%0d/%0d exp %0b/%0d/%0d",
                 guard, valid_out, a_out, b_out, exp_v, exp_a, exp_b);
      end
      checks++;
      if (a_out >= 12'(Q) || b_out >= 12'(Q)) begin
        errors++;
        $display("FAIL random_range got %0d/%0d exp < %0d", a_out, b_out, Q);
      end
    end
    checks++;
    if (mq.size() != 0 || sent != 1000) begin
      errors++;
      $display("FAIL random_drain got %0d pending %0d sent exp 0/1000",
               mq.size(), sent);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
